psram_responder: RTL and testbench

PSRAM_RESPONDER -- requirements
Module: psram_responder

---
 rtl/psram_pkg.sv | 12 +
 rtl/psram_responder_mem.sv | 24 ++
 rtl/psram_responder.sv | 109 ++++++++++
 tb/tb_psram_responder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/psram_pkg.sv
// psram_pkg: FSM state type and default parameters shared by the PSRAM responder files.
package psram_pkg;

    typedef enum logic [1:0] {IDLE, READ_WAIT, READ_DRIVE, WRITE} state_t;

    localparam int DEF_ADDRESS_BITS  = 22;
    localparam int DEF_DATA_BITS     = 16;
    localparam int DEF_BANK          = 0;
    localparam int DEF_ACCESS_CYCLES = 3;
    localparam int DEF_MEM_ADDR_BITS = 10;

endpackage

// File: rtl/psram_responder_mem.sv
// psram_responder_mem: single-port backing store with upper/lower byte enables and a
// registered read port (one clock of latency).
module psram_responder_mem #(
    parameter int ADDR_BITS = 10,
    parameter int DATA_BITS = 16
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [1:0]           be,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DATA_BITS-1:0] wdata,
    output logic [DATA_BITS-1:0] q
);
    localparam int HW = DATA_BITS / 2;

    logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we && be[0]) mem[addr][HW-1:0] <= wdata[HW-1:0];
        if (we && be[1]) mem[addr][DATA_BITS-1:HW] <= wdata[DATA_BITS-1:HW];
        q <= mem[addr];
    end

endmodule

// File: rtl/psram_responder.sv
// psram_responder: asynchronous-mode CellularRAM bank model answering muxed address/data
// accesses on one chip enable, with access counters and a sticky protocol-violation flag.
module psram_responder
    import psram_pkg::*;
#(
    parameter int ADDRESS_BITS  = DEF_ADDRESS_BITS,
    parameter int DATA_BITS     = DEF_DATA_BITS,
    parameter int BANK          = DEF_BANK,
    parameter int ACCESS_CYCLES = DEF_ACCESS_CYCLES,
    parameter int MEM_ADDR_BITS = DEF_MEM_ADDR_BITS
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [ADDRESS_BITS-DATA_BITS-1:0] cram_a,
    inout  wire  [DATA_BITS-1:0]              cram_dq,
    output logic                              cram_wait,
    input  logic                              cram_clk,
    input  logic                              cram_adv_n,
    input  logic                              cram_cre,
    input  logic                              cram_ce0_n,
    input  logic                              cram_ce1_n,
    input  logic                              cram_oe_n,
    input  logic                              cram_we_n,
    input  logic                              cram_ub_n,
    input  logic                              cram_lb_n,
    output logic [15:0]                       rd_count,
    output logic [15:0]                       wr_count,
    output logic                              protocol_err
);
    localparam int CW = $clog2(ACCESS_CYCLES + 1);

    state_t                   state, next;
    logic [CW-1:0]            cnt;
    logic [ADDRESS_BITS-1:0]  addr_in;
    logic [MEM_ADDR_BITS-1:0] addr_q;
    logic [DATA_BITS-1:0]     wdata_q, mem_q;
    logic [1:0]               be_q;
    logic ce_n, active, viol, latch, smp, have_sample, commit, rd_entry, dq_oe, unused_ok;

    if (ACCESS_CYCLES < 2) begin : g_access_check
        $error("ACCESS_CYCLES must be at least 2 to cover the store read latency");
    end

    assign ce_n      = (BANK != 0) ? cram_ce1_n : cram_ce0_n;
    assign active    = !ce_n && !cram_cre;
    assign viol      = active && !cram_oe_n && (!cram_we_n || !cram_adv_n);
    assign latch     = active && !cram_adv_n && !viol;
    assign addr_in   = {cram_a, cram_dq};
    assign cram_wait = 1'b0;
    assign cram_dq   = dq_oe ? mem_q : 'z;
    assign unused_ok = ^{cram_clk, addr_in};

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else          state <= next;

    // Deselect, configuration cycles and violations all abandon the current access.
    always_comb begin
        next = state;
        if (!active || viol) next = IDLE;
        else if (!cram_adv_n) next = cram_we_n ? READ_WAIT : WRITE;
        else if (state == READ_WAIT && cnt == CW'(ACCESS_CYCLES) && !cram_oe_n) next = READ_DRIVE;
        else if (state == WRITE && cram_we_n) next = IDLE;
    end

    always_comb begin
        smp      = state == WRITE && next == WRITE && !latch;
        commit   = state == WRITE && have_sample && (ce_n || (active && cram_we_n && cram_adv_n));
        rd_entry = state == READ_WAIT && next == READ_DRIVE;
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            cnt          <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            have_sample  <= 1'b0;
            dq_oe        <= 1'b0;
            rd_count     <= '0;
            wr_count     <= '0;
            protocol_err <= 1'b0;
        end else begin
            if (latch) addr_q <= addr_in[MEM_ADDR_BITS-1:0];
            if (smp) begin
                wdata_q <= cram_dq;
                be_q    <= ~{cram_ub_n, cram_lb_n};
            end
            cnt          <= latch ? CW'(1) : (state == READ_WAIT && cnt != CW'(ACCESS_CYCLES)) ? cnt + CW'(1) : cnt;
            have_sample  <= smp;
            dq_oe        <= state == READ_DRIVE && next == READ_DRIVE && !cram_oe_n;
            rd_count     <= rd_count + 16'(rd_entry);
            wr_count     <= wr_count + 16'(commit);
            protocol_err <= protocol_err || viol;
        end

    psram_responder_mem #(
        .ADDR_BITS(MEM_ADDR_BITS),
        .DATA_BITS(DATA_BITS)
    ) u_mem (
        .clk  (clk),
        .we   (commit),
        .be   (be_q),
        .addr (addr_q),
        .wdata(wdata_q),
        .q    (mem_q)
    );

endmodule

// File: tb/tb_psram_responder.sv
// tb_psram_responder: randomized scoreboard bench; reads push expected words from an
// associative-array memory model, a monitor pops them when the DUT starts a read.
module tb_psram_responder;
    localparam int AB  = 22;
    localparam int DB  = 16;
    localparam int AC  = 3;
    localparam int MAB = 10;
    localparam logic [DB-1:0] ZV = '1;  // value of the pulled-up bus when nobody drives it

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic [AB-DB-1:0] cram_a = '0;
    wire  [DB-1:0] cram_dq;
    logic [DB-1:0] tb_dq = '0;
    logic tb_oe = 1'b0;
    logic cram_clk = 1'b0;
    logic cram_adv_n = 1'b1, cram_cre = 1'b0, cram_ce0_n = 1'b1, cram_ce1_n = 1'b1;
    logic cram_oe_n = 1'b1, cram_we_n = 1'b1, cram_ub_n = 1'b0, cram_lb_n = 1'b0;
    logic cram_wait, protocol_err;
    logic [15:0] rd_count, wr_count;

    int checks = 0;
    int passes = 0;
    int rd_exp = 0;
    int wr_exp = 0;
    logic [DB-1:0] model [int];
    logic [DB-1:0] exp_q [$];
    int idxs [6] = '{3, 77, 200, 511, 1000, 1023};

    assign cram_dq = tb_oe ? tb_dq : 'z;
    pullup (cram_dq);

    always #5 clk = ~clk;

    psram_responder #(
        .ADDRESS_BITS(AB), .DATA_BITS(DB), .BANK(0), .ACCESS_CYCLES(AC), .MEM_ADDR_BITS(MAB)
    ) dut (
        .clk(clk), .reset_n(reset_n), .cram_a(cram_a), .cram_dq(cram_dq), .cram_wait(cram_wait),
        .cram_clk(cram_clk), .cram_adv_n(cram_adv_n), .cram_cre(cram_cre),
        .cram_ce0_n(cram_ce0_n), .cram_ce1_n(cram_ce1_n), .cram_oe_n(cram_oe_n),
        .cram_we_n(cram_we_n), .cram_ub_n(cram_ub_n), .cram_lb_n(cram_lb_n),
        .rd_count(rd_count), .wr_count(wr_count), .protocol_err(protocol_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic release_bus();
        cram_ce0_n = 1'b1; cram_ce1_n = 1'b1; cram_adv_n = 1'b1; cram_oe_n = 1'b1;
        cram_we_n = 1'b1; cram_cre = 1'b0; cram_ub_n = 1'b0; cram_lb_n = 1'b0; tb_oe = 1'b0;
    endtask

    task automatic latch_addr(input logic [AB-1:0] addr, input bit is_wr, input bit other);
        @(negedge clk);
        cram_ce0_n = other; cram_ce1_n = !other; cram_cre = 1'b0;
        cram_adv_n = 1'b0; cram_we_n = !is_wr; cram_oe_n = 1'b1;
        {cram_a, tb_dq} = addr; tb_oe = 1'b1;
    endtask

    task automatic wr_access(input logic [AB-1:0] addr, input logic [DB-1:0] data,
                             input bit ub, input bit lb, input bit other);
        int idx;
        logic [DB-1:0] old;
        latch_addr(addr, 1'b1, other);
        @(negedge clk);
        cram_adv_n = 1'b1; cram_we_n = 1'b0; tb_dq = data; cram_ub_n = ub; cram_lb_n = lb;
        @(negedge clk);
        cram_we_n = 1'b1; tb_oe = 1'b0;
        @(negedge clk);
        release_bus();
        if (!other) begin
            idx = int'(addr[MAB-1:0]);
            old = model.exists(idx) ? model[idx] : '0;
            model[idx] = {ub ? old[15:8] : data[15:8], lb ? old[7:0] : data[7:0]};
            wr_exp++;
        end
        check("wr_count", wr_count, 32'(wr_exp));
    endtask

    // oe_n asserts right after the latch edge; data must appear only from latch edge +4.
    task automatic rd_access(input logic [AB-1:0] addr, input bit other);
        latch_addr(addr, 1'b0, other);
        @(negedge clk);
        cram_adv_n = 1'b1; tb_oe = 1'b0; cram_oe_n = 1'b0;
        if (!other) begin
            exp_q.push_back(model[int'(addr[MAB-1:0])]);
            rd_exp++;
        end
        @(negedge clk); check("dq_z_edge1", cram_dq, ZV);
        @(negedge clk); check("dq_z_edge2", cram_dq, ZV);
        @(negedge clk); check("dq_z_edge3", cram_dq, ZV);
        @(negedge clk);
        if (other) check("dq_z_other_bank", cram_dq, ZV);
        cram_oe_n = 1'b1;
        @(negedge clk); check("dq_z_release", cram_dq, ZV);
        release_bus();
        check("rd_count", rd_count, 32'(rd_exp));
    endtask

    initial begin : monitor
        logic [15:0] prev;
        logic [DB-1:0] e;
        bit pend;
        prev = '0;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev = rd_count;
                pend = 1'b0;
            end else begin
                if (pend) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL rd_unexpected: read data %0h with no read outstanding", cram_dq);
                    end else begin
                        e = exp_q.pop_front();
                        check("rd_data", cram_dq, e);
                    end
                    pend = 1'b0;
                end
                if (rd_count != prev) begin
                    pend = 1'b1;
                    prev = rd_count;
                end
            end
        end
    end

    initial begin : stimulus
        int k;
        logic [AB-1:0] a;
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_rd_count", rd_count, 0);
        check("rst_wr_count", wr_count, 0);
        check("rst_protocol_err", protocol_err, 0);
        check("rst_cram_wait", cram_wait, 0);
        check("rst_dq_z", cram_dq, ZV);
        #2 reset_n = 1'b1;

        wr_access(22'h000123, 16'hBEEF, 1'b0, 1'b0, 1'b0);
        rd_access(22'h000123, 1'b0);
        wr_access(22'h000005, 16'h1234, 1'b0, 1'b0, 1'b0);
        wr_access(22'h000005, 16'hAB00, 1'b0, 1'b1, 1'b0);
        rd_access(22'h000005, 1'b0);

        wr_access(22'h000123, 16'h5555, 1'b0, 1'b0, 1'b1);
        rd_access(22'h000123, 1'b1);
        rd_access(22'h2A0123, 1'b0);

        latch_addr(22'h000123, 1'b1, 1'b0);
        @(negedge clk);
        cram_adv_n = 1'b1; cram_we_n = 1'b0; tb_dq = 16'h1111;
        rd_access(22'h000123, 1'b0);
        check("restart_wr_count", wr_count, 32'(wr_exp));

        @(negedge clk);
        cram_ce0_n = 1'b0; cram_cre = 1'b1; cram_adv_n = 1'b0; cram_oe_n = 1'b0; cram_we_n = 1'b0;
        tb_oe = 1'b1; cram_a = '0; tb_dq = 16'h0123;
        @(negedge clk); cram_adv_n = 1'b1; tb_dq = 16'h9999;
        @(negedge clk); cram_we_n = 1'b1; cram_oe_n = 1'b1;
        @(negedge clk); release_bus();
        @(negedge clk);
        check("cre_protocol_err", protocol_err, 0);
        check("cre_wr_count", wr_count, 32'(wr_exp));
        check("cre_rd_count", rd_count, 32'(rd_exp));
        rd_access(22'h000123, 1'b0);

        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 5);
            a = AB'($urandom);
            a[MAB-1:0] = MAB'(idxs[k]);
            if (!model.exists(idxs[k])) wr_access(a, DB'($urandom_range(0, 16'hFFFE)), 1'b0, 1'b0, 1'b0);
            else if ($urandom_range(0, 1) == 1) wr_access(a, DB'($urandom), 1'($urandom), 1'($urandom), 1'b0);
            else rd_access(a, 1'b0);
        end

        latch_addr(22'h000123, 1'b1, 1'b0);
        @(negedge clk); cram_adv_n = 1'b1; cram_we_n = 1'b0; tb_dq = 16'h2222;
        @(negedge clk); cram_oe_n = 1'b0;
        @(negedge clk); release_bus();
        @(negedge clk);
        check("viol_protocol_err", protocol_err, 1);
        check("viol_wr_count", wr_count, 32'(wr_exp));
        rd_access(22'h000123, 1'b0);
        check("viol_sticky", protocol_err, 1);

        latch_addr(22'h000005, 1'b1, 1'b0);
        @(negedge clk); cram_adv_n = 1'b1; cram_we_n = 1'b0; tb_dq = 16'h7777;
        @(negedge clk);
        #2 reset_n = 1'b0;
        @(negedge clk);
        release_bus();
        rd_exp = 0;
        wr_exp = 0;
        #2 reset_n = 1'b1;
        @(negedge clk);
        check("midwr_wr_count", wr_count, 0);
        check("midwr_rd_count", rd_count, 0);
        check("midwr_protocol_err", protocol_err, 0);
        rd_access(22'h000005, 1'b0);

        @(negedge clk);
        cram_ce0_n = 1'b0; cram_adv_n = 1'b0; cram_oe_n = 1'b0; cram_we_n = 1'b1;
        tb_oe = 1'b1; cram_a = '0; tb_dq = 16'h0005;
        @(negedge clk); release_bus();
        @(negedge clk);
        check("advoe_protocol_err", protocol_err, 1);
        check("advoe_rd_count", rd_count, 32'(rd_exp));
        check("advoe_dq_z", cram_dq, ZV);

        for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(negedge clk);
        check("scoreboard_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
